// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer,
// flush-driven bubble injection and a saturating stall counter.
module pipe_stage_skid_reg #(
    parameter int                CTRL_W      = 12,
    parameter int                DATA_W      = 64,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}},
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;

    logic in_ready_q, out_valid_q;
    logic [1:0] occ_q, occ_d;
    logic [STALL_CNT_W-1:0] stall_q;

    logic it, ot;

    assign it = in_valid & in_ready_q;
    assign ot = out_valid_q & out_ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d  = EMPTY;
            m_ctrl_d = '0;
            m_data_d = BUBBLE_DATA;
            s_ctrl_d = '0;
            s_data_d = BUBBLE_DATA;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (it) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (it && ot) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (it) begin
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                        state_d  = FULL;
                    end else if (ot) begin
                        m_ctrl_d = '0;
                        m_data_d = BUBBLE_DATA;
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (ot) begin
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        s_ctrl_d = '0;
                        s_data_d = BUBBLE_DATA;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    m_ctrl_d = '0;
                    m_data_d = BUBBLE_DATA;
                    s_ctrl_d = '0;
                    s_data_d = BUBBLE_DATA;
                end
            endcase
        end
    end

    always_comb begin
        occ_d = 2'd0;
        unique case (state_d)
            EMPTY:   occ_d = 2'd0;
            ONE:     occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // Handshake outputs are flopped from next state: no out_ready->in_ready path.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            m_ctrl_q    <= '0;
            m_data_q    <= BUBBLE_DATA;
            s_ctrl_q    <= '0;
            s_data_q    <= BUBBLE_DATA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            m_ctrl_q    <= m_ctrl_d;
            m_data_q    <= m_data_d;
            s_ctrl_q    <= s_ctrl_d;
            s_data_q    <= s_data_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= occ_d;
            if (out_valid_q && !out_ready && !(&stall_q))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_ctrl     = m_ctrl_q;
    assign out_data     = m_data_q;
    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed and randomized checks of pipe_stage_skid_reg against
// an in-order queue reference model.
module tb_pipe_stage_skid_reg;

    localparam int CW = 12;
    localparam int DW = 64;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam logic [DW-1:0] BUB = 64'h0000_0013_0000_0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cycles;

    pipe_stage_skid_reg #(
        .CTRL_W(CW), .DATA_W(DW), .BUBBLE_DATA(BUB), .STALL_CNT_W(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   mstall = 0;
    bit   armed = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the model, then advance one clock.
    task automatic tick();
        bit   it, ot, stl;
        ent_t e;
        if (armed) begin
            check("out_valid", DW'(out_valid), DW'(q.size() != 0));
            check("in_ready", DW'(in_ready), DW'(q.size() < 2));
            check("occupancy", DW'(occupancy), DW'(q.size()));
            check("stall_cycles", DW'(stall_cycles), DW'(mstall));
            check("out_ctrl", DW'(out_ctrl), q.size() ? DW'(q[0].c) : '0);
            check("out_data", out_data, q.size() ? q[0].d : BUB);
        end
        it  = in_valid && q.size() < 2;
        ot  = q.size() > 0 && out_ready;
        stl = q.size() > 0 && !out_ready;
        e.c = in_ctrl;
        e.d = in_data;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            q.delete();
            mstall = 0;
            armed = 1;
        end else begin
            if (stl && mstall < SMAX) mstall++;
            if (flush) q.delete();
            else begin
                if (ot) void'(q.pop_front());
                if (it) q.push_back(e);
            end
        end
    endtask

    task automatic drive(bit v, logic [CW-1:0] c, logic [DW-1:0] d,
                         bit r, bit f);
        in_valid = v;
        in_ctrl = c;
        in_data = d;
        out_ready = r;
        flush = f;
        tick();
    endtask

    initial begin
        // reset
        reset_n = 1'b0;
        drive(0, '0, '0, 0, 0);
        drive(0, '0, '0, 0, 0);
        reset_n = 1'b1;
        check("rst_occ", DW'(occupancy), 0);
        check("rst_in_ready", DW'(in_ready), 1);
        check("rst_out_data", out_data, BUB);

        // stream A,B,C at full throughput
        drive(1, 12'hA01, 64'hAAAA, 1, 0);
        check("lat_valid", DW'(out_valid), 1);
        drive(1, 12'hB02, 64'hBBBB, 1, 0);
        drive(1, 12'hC03, 64'hCCCC, 1, 0);
        check("stream_c", out_data, 64'hCCCC);
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);
        check("stream_stall", DW'(stall_cycles), 0);

        // skid: A held, B lands in S, hold 3 cycles
        drive(1, 12'h111, 64'h1111, 0, 0);
        drive(1, 12'h222, 64'h2222, 0, 0);
        check("skid_occ", DW'(occupancy), 2);
        check("skid_in_ready", DW'(in_ready), 0);
        repeat (3) drive(0, '0, '0, 0, 0);
        check("skid_stall", DW'(stall_cycles), 4);
        drive(0, '0, '0, 1, 0);
        check("skid_b_out", out_data, 64'h2222);
        drive(0, '0, '0, 1, 0);

        // flush while FULL with a same-cycle input
        drive(1, 12'h333, 64'h3333, 0, 0);
        drive(1, 12'h444, 64'h4444, 0, 0);
        drive(1, 12'h555, 64'h5555, 1, 1);
        check("flush_valid", DW'(out_valid), 0);
        check("flush_ctrl", DW'(out_ctrl), 0);
        check("flush_data", out_data, BUB);
        check("flush_stall", DW'(stall_cycles), 5);
        drive(0, '0, '0, 1, 0);

        // stall counter saturation
        drive(1, 12'h666, 64'h6666, 0, 0);
        repeat (SMAX + 6) drive(0, '0, '0, 0, 0);
        check("sat_stall", DW'(stall_cycles), SMAX);

        // reset with occupancy 2
        drive(1, 12'h777, 64'h7777, 0, 0);
        check("pre_rst_occ", DW'(occupancy), 2);
        reset_n = 1'b0;
        drive(0, '0, '0, 0, 0);
        reset_n = 1'b1;
        check("mid_rst_valid", DW'(out_valid), 0);
        check("mid_rst_stall", DW'(stall_cycles), 0);
        drive(1, 12'h888, 64'h8888, 0, 0);
        check("post_rst_lat", out_data, 64'h8888);
        drive(0, '0, '0, 1, 0);

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            logic [CW-1:0] c;
            logic [DW-1:0] d;
            c = CW'($urandom);
            d = {$urandom, $urandom};
            drive($urandom_range(0, 9) < 7, c, d,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        end
        repeat (4) drive(0, '0, '0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
